// File: rtl/ahb_pkg.sv
// Shared AHB encodings: transfer types, response codes and default-slave state.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // True for transfers that need a response (NONSEQ or SEQ).
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ with the two-cycle ERROR response.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset,
  input  logic       accept,
  input  logic [1:0] htrans,
  output logic       hready,
  output logic [1:0] hresp
);

  ds_state_e state, state_nxt;

  always_ff @(posedge hclk) begin
    if (hreset) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (accept && is_active(htrans)) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = (accept && is_active(htrans)) ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state)
      DS_ERR1: begin hready = 1'b0; hresp = HRESP_ERROR; end
      DS_ERR2: begin hready = 1'b1; hresp = HRESP_ERROR; end
      default: begin hready = 1'b1; hresp = HRESP_OKAY;  end
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// Slave-to-master response mux with data-phase select register.
// Define AHB_DEFAULT_SLAVE_EN to answer unmapped NONSEQ/SEQ with ERROR.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [NUM_SLAVES-1:0]        hsel_s,
  input  logic [1:0]                   htrans,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]        hready_s,
  input  logic [2*NUM_SLAVES-1:0]      hresp_s,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready,
  output logic [1:0]                   hresp,
  output logic [NUM_SLAVES-1:0]        hsel_dp
);

  logic [NUM_SLAVES-1:0] sel_dp;
  logic [NUM_SLAVES-1:0] sel_low;

  // Isolate the lowest set bit so overlapping decodes resolve to one slave.
  assign sel_low = hsel_s & (~hsel_s + NUM_SLAVES'(1));

  always_ff @(posedge hclk) begin
    if (hreset)      sel_dp <= '0;
    else if (hready) sel_dp <= sel_low;
  end

  assign hsel_dp = sel_dp;

`ifdef AHB_DEFAULT_SLAVE_EN
  logic       def_dp;
  logic       ds_accept;
  logic       ds_hready;
  logic [1:0] ds_hresp;

  always_ff @(posedge hclk) begin
    if (hreset)      def_dp <= 1'b0;
    else if (hready) def_dp <= (hsel_s == '0) && is_active(htrans);
  end

  assign ds_accept = hready && (hsel_s == '0);

  ahb_default_slave u_default_slave (
    .hclk   (hclk),
    .hreset (hreset),
    .accept (ds_accept),
    .htrans (htrans),
    .hready (ds_hready),
    .hresp  (ds_hresp)
  );
`else
  logic unused_htrans;
  assign unused_htrans = ^htrans;
`endif

  // Data-phase routing; an empty select answers OKAY with zero data.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
`ifdef AHB_DEFAULT_SLAVE_EN
    if (def_dp) begin
      hready = ds_hready;
      hresp  = ds_hresp;
    end
`endif
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_dp[i]) begin
        hrdata = hrdata_s[i*DATA_W +: DATA_W];
        hready = hready_s[i];
        hresp  = hresp_s[2*i +: 2];
      end
    end
  end

endmodule
